// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one fixed-latency external pipeline, with tag tracking and flush/drain control.
// Optional DELAY_ARBITER_STATS_EN adds a 32-bit issue counter output.
module delay_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               i_req_valid,
    input  logic [N_REQ*WIDTH-1:0]         i_req_data,
    output logic [N_REQ-1:0]               o_req_ready,
    output logic [WIDTH-1:0]               o_pipe_in,
    input  logic [WIDTH-1:0]               i_pipe_out,
    output logic [N_REQ-1:0]               o_rsp_valid,
    output logic [WIDTH-1:0]               o_rsp_data,
    input  logic                           i_flush,
    output logic                           o_flush_done,
    output logic [$clog2(LATENCY+1)-1:0]   o_inflight
`ifdef DELAY_ARBITER_STATS_EN
    ,
    output logic [31:0]                    o_issue_count
`endif
);

    localparam int IDXW = $clog2(N_REQ);
    localparam int CNTW = $clog2(LATENCY+1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            r_state;
    logic              r_flushDone;
    logic [IDXW-1:0]   r_ptr;
    logic [CNTW-1:0]   r_inflight;
    logic [LATENCY-1:0] r_tagValid;
    logic [IDXW-1:0]   r_tagId [LATENCY];

    logic [N_REQ-1:0]  w_grant;
    logic [IDXW-1:0]   w_gntIdx;
    logic [IDXW-1:0]   w_searchIdx;
    logic              w_found;
    logic              w_issue;
    logic              w_ret;
    logic [WIDTH-1:0]  w_pipeIn;
    logic [CNTW-1:0]   w_inflightNext;

    // Search starts just past the last winner; rst_n gating keeps grants silent during reset.
    always_comb begin
        w_grant     = '0;
        w_gntIdx    = '0;
        w_searchIdx = '0;
        w_found     = 1'b0;
        if (rst_n && r_state == ST_RUN && !i_flush) begin
            for (int k = 1; k <= N_REQ; k++) begin
                w_searchIdx = IDXW'((int'(r_ptr) + k) % N_REQ);
                if (!w_found && i_req_valid[w_searchIdx]) begin
                    w_found  = 1'b1;
                    w_gntIdx = w_searchIdx;
                end
            end
        end
        if (w_found) begin
            w_grant[w_gntIdx] = 1'b1;
        end
    end

    always_comb begin
        w_pipeIn = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_pipeIn = i_req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_issue = w_found;
    assign w_ret   = r_tagValid[LATENCY-1];

    always_comb begin
        w_inflightNext = r_inflight;
        if (w_issue && !w_ret) begin
            w_inflightNext = r_inflight + CNTW'(1);
        end else if (!w_issue && w_ret) begin
            w_inflightNext = r_inflight - CNTW'(1);
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_ret && r_tagId[LATENCY-1] == IDXW'(i)) begin
                o_rsp_valid[i] = 1'b1;
            end
        end
    end

    assign o_req_ready  = w_grant;
    assign o_pipe_in    = w_pipeIn;
    assign o_rsp_data   = i_pipe_out;
    assign o_flush_done = r_flushDone;
    assign o_inflight   = r_inflight;

    // Tag stage k describes the item that entered the external pipeline k+1 cycles ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tagValid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tagId[i] <= '0;
            end
        end else begin
            for (int i = LATENCY-1; i > 0; i--) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagId[i]    <= r_tagId[i-1];
            end
            r_tagValid[0] <= w_issue;
            r_tagId[0]    <= w_gntIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= IDXW'(N_REQ-1);
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflightNext;
            if (w_issue) begin
                r_ptr <= w_gntIdx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flushDone <= 1'b0;
        end else begin
            r_flushDone <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (i_flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_inflightNext == '0) begin
                        r_state     <= ST_DONE;
                        r_flushDone <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef DELAY_ARBITER_STATS_EN
    logic [31:0] r_issueCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issueCount <= '0;
        end else if (w_issue) begin
            r_issueCount <= r_issueCount + 32'd1;
        end
    end

    assign o_issue_count = r_issueCount;
`endif

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the delay pipeline (2..8).
REQ-002 Parameter WIDTH, default 16: data bitwidth.
REQ-003 Parameter LATENCY, default 4: fixed latency of the external pipeline in cycles (>=1).
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  N_REQ  per-requester request.
REQ-007 req_data  input  N_REQ*WIDTH  per-requester payload; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_ready  output  N_REQ  one-hot grant, combinational.
REQ-009 pipe_in  output  WIDTH  payload to the shared pipeline.
REQ-010 pipe_out  input  WIDTH  pipeline output, equal to pipe_in from exactly LATENCY cycles earlier.
REQ-011 rsp_valid  output  N_REQ  one-hot return strobe to the owning requester.
REQ-012 rsp_data  output  WIDTH  equals pipe_out.
REQ-013 flush  input  1  request to stop issuing and drain the pipeline.
REQ-014 flush_done  output  1  single-cycle pulse when the drain completes.
REQ-015 inflight  output  $clog2(LATENCY+1)  number of issued but not yet returned items.

Function
REQ-016 Grants SHALL be issued only in state RUN, at most one per cycle, and only to a requester with req_valid=1.
REQ-017 Arbitration SHALL be round-robin: the search starts at (last granted index + 1) mod N_REQ.
REQ-018 Issue occurs when req_valid[i] & req_ready[i]; the pointer SHALL update only on issue.
REQ-019 pipe_in SHALL carry the granted requester's payload; with no grant, pipe_in SHALL be 0.
REQ-020 An internal LATENCY-stage tag shift register SHALL carry {valid, id} for every cycle, with valid=0 when there is no issue.
REQ-021 When the tag at the last stage is valid, rsp_valid[id] SHALL be 1 in the same cycle that pipe_out holds the item; otherwise rsp_valid SHALL be 0.
REQ-022 Per-requester response order SHALL equal issue order, and total latency issue->rsp_valid SHALL be LATENCY cycles.
REQ-023 inflight SHALL increment on issue, decrement on return, and stay unchanged when both occur in the same cycle; it never exceeds LATENCY.
REQ-024 FSM states are RUN, DRAIN and DONE; reset state is RUN.
REQ-025 RUN->DRAIN when flush=1; no grants are issued in the flush cycle or afterwards.
REQ-026 DRAIN->DONE when inflight==0 (counted after that cycle's return); returns continue normally during DRAIN.
REQ-027 DONE asserts flush_done for exactly one cycle, then returns to RUN; if flush is still 1 in RUN, the FSM re-enters DRAIN.
REQ-028 flush with inflight already 0 SHALL produce flush_done 2 cycles after flush is sampled.

Reset
REQ-029 On rst_n=0: tags cleared, inflight=0, pointer=N_REQ-1 (requester 0 is searched first), FSM in RUN, rsp_valid=0, flush_done=0.
REQ-030 Reset mid-operation SHALL discard all in-flight tags; stale pipe_out data after reset SHALL NOT produce rsp_valid.
REQ-031 Release of rst_n SHALL take effect on the next rising clk edge with no spurious grant while rst_n=0.

Configuration
REQ-032 Macro DELAY_ARBITER_STATS_EN: when defined, output issue_count [31:0] SHALL count issues (reset 0, wraps at 2^32).
REQ-033 Without DELAY_ARBITER_STATS_EN, the issue_count port and its counter SHALL be absent and all other behaviour is unchanged.

Verification
REQ-034 Single request: req_valid=0001, data 0x1234 -> req_ready=0001 same cycle; rsp_valid=0001 and rsp_data=0x1234 LATENCY=4 cycles later.
REQ-035 All four requesters held valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; returns arrive in the same order, each exactly 4 cycles after its issue.
REQ-036 Continuous issue -> inflight rises 1,2,3,4 and holds at 4 while issue and return coincide.
REQ-037 flush pulsed with inflight=3 -> no further grants; flush_done pulses one cycle after the last return; grants resume the following cycle.
REQ-038 rst_n low with inflight=2, then released -> no rsp_valid for 4 cycles after release; inflight=0; first grant goes to requester 0.
REQ-039 With DELAY_ARBITER_STATS_EN, 10 issues -> issue_count=10; reset -> 0.
